// File: rtl/sid_write_scheduler.sv
// Round-robin write scheduler for the sid8580 core. It merges host and J1 register writes
// into a small FIFO and retires them one per 1 MHz clock-enable tick derived from vga_clk.
module sid_write_scheduler #(
  parameter int DIV     = 50,
  parameter int DEPTH   = 8,
  parameter int LASTREG = 24
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic [4:0]                 a_addr,
  input  logic [7:0]                 a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [4:0]                 b_addr,
  input  logic [7:0]                 b_data,
  output logic                       b_ready,
  output logic                       ce_1m,
  output logic                       sid_we,
  output logic [4:0]                 sid_addr,
  output logic [7:0]                 sid_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       drop_err,
  input  logic                       clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    tick_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          rr_b;
  logic [12:0]   mem [DEPTH];

  logic          not_full;
  logic          gnt_a;
  logic          gnt_b;
  logic          gnt;
  logic [4:0]    win_addr;
  logic [7:0]    win_data;
  logic          in_range;
  logic          push;
  logic          drop;
  logic          pop;
  logic [12:0]   head;

  // Ready looks only at the registered level, so a same-cycle pop never frees a slot early.
  assign not_full = (level < LW'(DEPTH));
  assign gnt_a    = a_valid & not_full & (~b_valid | ~rr_b);
  assign gnt_b    = b_valid & not_full & (~a_valid | rr_b);
  assign gnt      = gnt_a | gnt_b;
  assign a_ready  = not_full & ~gnt_b;
  assign b_ready  = not_full & ~gnt_a;

  assign win_addr = gnt_a ? a_addr : b_addr;
  assign win_data = gnt_a ? a_data : b_data;
  assign in_range = (win_addr <= 5'(LASTREG));
  assign push     = gnt & in_range;
  assign drop     = gnt & ~in_range;

  assign ce_1m    = (tick_cnt == 8'(DIV - 1));
  assign pop      = ce_1m & (level != '0);
  assign head     = mem[rd_ptr];
  assign sid_we   = pop;
  assign sid_addr = pop ? head[12:8] : 5'd0;
  assign sid_data = pop ? head[7:0]  : 8'd0;

  assign fifo_level = level;

  // Storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge vga_clk) begin
    if (push) mem[wr_ptr] <= {win_addr, win_data};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rr_b     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      tick_cnt <= ce_1m ? 8'd0 : tick_cnt + 8'd1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (gnt) rr_b <= gnt_a;
      if (drop)         drop_err <= 1'b1;
      else if (clr_err) drop_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sid_write_scheduler.sv
// Bench for sid_write_scheduler: a table of hand-derived cycle vectors, a few corner sequences,
// and a random run, all checked against a queue-based reference model of the scheduling rules.
module tb_sid_write_scheduler;

  localparam int DIV     = 50;
  localparam int DEPTH   = 8;
  localparam int LASTREG = 24;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       a_valid = 1'b0;
  logic [4:0] a_addr  = 5'd0;
  logic [7:0] a_data  = 8'd0;
  logic       b_valid = 1'b0;
  logic [4:0] b_addr  = 5'd0;
  logic [7:0] b_data  = 8'd0;
  logic       clr_err = 1'b0;
  logic       a_ready;
  logic       b_ready;
  logic       ce_1m;
  logic       sid_we;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic [3:0] fifo_level;
  logic       drop_err;

  sid_write_scheduler #(.DIV(DIV), .DEPTH(DEPTH), .LASTREG(LASTREG)) dut (
    .vga_clk(vga_clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .ce_1m(ce_1m), .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .fifo_level(fifo_level), .drop_err(drop_err), .clr_err(clr_err)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: cycle index since reset release, queue of {addr,data}, arbiter owner.
  logic [12:0] mq[$];
  bit          m_rr_b;
  bit          m_drop;
  int          m_cyc;
  bit          last_ga;
  bit          last_gb;

  typedef struct {
    int cyc;
    int av, aa, ad, bv, ba, bd, clr;
    int ard, brd, ce, we, sa, sd, lvl, drop;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int cyc, int av, int aa, int ad, int bv, int ba, int bd, int clr,
                              int ard, int brd, int ce, int we, int sa, int sd, int lvl, int drop);
    vec_t v;
    v.cyc = cyc; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.clr = clr;
    v.ard = ard; v.brd = brd; v.ce = ce; v.we = we; v.sa = sa; v.sd = sd; v.lvl = lvl; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic set_idle();
    a_valid = 1'b0; a_addr = 5'd0; a_data = 8'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 8'd0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    repeat (3) @(posedge vga_clk);
    #2 reset = 1'b0;
    mq.delete();
    m_rr_b = 1'b0;
    m_drop = 1'b0;
    m_cyc  = 0;
  endtask

  // One cycle: drive inputs at the falling edge, compare against the model, then advance the model.
  task automatic step(input int av, input int aa, input int ad, input int bv, input int ba,
                      input int bd, input int clr);
    int          lvl;
    bit          full, ga, gb, ece, ewe;
    logic [12:0] h;
    logic [4:0]  wa;
    logic [7:0]  wd;
    @(negedge vga_clk);
    a_valid = 1'(av); a_addr = 5'(aa); a_data = 8'(ad);
    b_valid = 1'(bv); b_addr = 5'(ba); b_data = 8'(bd);
    clr_err = 1'(clr);
    #1;
    lvl  = mq.size();
    full = (lvl >= DEPTH);
    ga   = (av != 0) && !full && ((bv == 0) || !m_rr_b);
    gb   = (bv != 0) && !full && ((av == 0) || m_rr_b);
    ece  = ((m_cyc % DIV) == DIV - 1);
    ewe  = ece && (lvl > 0);
    h    = ewe ? mq[0] : 13'd0;
    chk("a_ready",    32'(a_ready),    32'(!full && !gb));
    chk("b_ready",    32'(b_ready),    32'(!full && !ga));
    chk("ce_1m",      32'(ce_1m),      32'(ece));
    chk("sid_we",     32'(sid_we),     32'(ewe));
    chk("sid_addr",   32'(sid_addr),   32'(h[12:8]));
    chk("sid_data",   32'(sid_data),   32'(h[7:0]));
    chk("fifo_level", 32'(fifo_level), 32'(lvl));
    chk("drop_err",   32'(drop_err),   32'(m_drop));
    if (ewe) void'(mq.pop_front());
    wa = 5'd0;
    wd = 8'd0;
    if (ga || gb) begin
      wa = ga ? 5'(aa) : 5'(ba);
      wd = ga ? 8'(ad) : 8'(bd);
      if (int'(wa) <= LASTREG) mq.push_back({wa, wd});
      m_rr_b = ga;
    end
    if ((ga || gb) && int'(wa) > LASTREG) m_drop = 1'b1;
    else if (clr != 0)                   m_drop = 1'b0;
    last_ga = ga;
    last_gb = gb;
    m_cyc++;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ri;
    int acc;
    int nwe;
    bit a_pend, b_pend;
    int pa, pd, pb, pe, rate;

    // cyc, A(v,addr,data), B(v,addr,data), clr | a_rdy, b_rdy, ce, we, addr, data, level, drop
    tv.push_back(mk(  0, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,0,0));
    tv.push_back(mk( 10, 1,'h00,'h00, 1,'h07,'h07, 0, 1,0,0,0,'h00,'h00,0,0));
    tv.push_back(mk( 11, 1,'h01,'h01, 1,'h07,'h07, 0, 0,1,0,0,'h00,'h00,1,0));
    tv.push_back(mk( 12, 1,'h01,'h01, 1,'h08,'h08, 0, 1,0,0,0,'h00,'h00,2,0));
    tv.push_back(mk( 13, 1,'h02,'h02, 1,'h08,'h08, 0, 0,1,0,0,'h00,'h00,3,0));
    tv.push_back(mk( 14, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,4,0));
    tv.push_back(mk( 20, 1,'h04,'h41, 0,'h00,'h00, 0, 1,0,0,0,'h00,'h00,4,0));
    tv.push_back(mk( 21, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,5,0));
    tv.push_back(mk( 48, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,5,0));
    tv.push_back(mk( 49, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,1,1,'h00,'h00,5,0));
    tv.push_back(mk( 50, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,4,0));
    tv.push_back(mk( 99, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,1,1,'h07,'h07,4,0));
    tv.push_back(mk(149, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,1,1,'h01,'h01,3,0));
    tv.push_back(mk(199, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,1,1,'h08,'h08,2,0));
    tv.push_back(mk(249, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,1,1,'h04,'h41,1,0));
    tv.push_back(mk(250, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,0,0));
    tv.push_back(mk(260, 1,'h1B,'h55, 0,'h00,'h00, 0, 1,0,0,0,'h00,'h00,0,0));
    tv.push_back(mk(261, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,0,1));
    tv.push_back(mk(262, 0,'h00,'h00, 0,'h00,'h00, 1, 1,1,0,0,'h00,'h00,0,1));
    tv.push_back(mk(263, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,0,0,'h00,'h00,0,0));
    tv.push_back(mk(299, 0,'h00,'h00, 0,'h00,'h00, 0, 1,1,1,0,'h00,'h00,0,0));

    do_reset();
    ri = 0;
    for (int c = 0; c < 300; c++) begin
      if (ri < tv.size() && tv[ri].cyc == c) begin
        step(tv[ri].av, tv[ri].aa, tv[ri].ad, tv[ri].bv, tv[ri].ba, tv[ri].bd, tv[ri].clr);
        chk($sformatf("tv%0d_a_ready", c),  32'(a_ready),    32'(tv[ri].ard));
        chk($sformatf("tv%0d_b_ready", c),  32'(b_ready),    32'(tv[ri].brd));
        chk($sformatf("tv%0d_ce_1m", c),    32'(ce_1m),      32'(tv[ri].ce));
        chk($sformatf("tv%0d_sid_we", c),   32'(sid_we),     32'(tv[ri].we));
        chk($sformatf("tv%0d_sid_addr", c), 32'(sid_addr),   32'(tv[ri].sa));
        chk($sformatf("tv%0d_sid_data", c), 32'(sid_data),   32'(tv[ri].sd));
        chk($sformatf("tv%0d_level", c),    32'(fifo_level), 32'(tv[ri].lvl));
        chk($sformatf("tv%0d_drop", c),     32'(drop_err),   32'(tv[ri].drop));
        ri++;
      end else begin
        idle_step();
      end
    end

    // Fill from B with no tick, then a ninth write waits for the slot freed by the cycle-49 pop.
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i, 'h80 + i, 0);
    acc = -1;
    for (int k = 0; k < 100 && acc < 0; k++) begin
      step(0, 0, 0, 1, 'h10, 'h99, 0);
      if (k == 0) begin
        chk("fill_full_level", 32'(fifo_level), 32'd8);
        chk("fill_full_b_ready", 32'(b_ready), 32'd0);
      end
      if (b_ready === 1'b1) acc = m_cyc - 1;
    end
    chk("fill_accept_cycle", acc, 50);
    idle_step();
    chk("fill_level_after", 32'(fifo_level), 32'd8);

    // Push into an empty FIFO on a tick cycle is held until the following tick.
    do_reset();
    for (int c = 0; c < 49; c++) idle_step();
    step(1, 'h05, 'h22, 0, 0, 0, 0);
    chk("tickpush_ce49", 32'(ce_1m), 32'd1);
    chk("tickpush_we49", 32'(sid_we), 32'd0);
    idle_step();
    chk("tickpush_level50", 32'(fifo_level), 32'd1);
    for (int c = 51; c < 99; c++) idle_step();
    idle_step();
    chk("tickpush_we99", 32'(sid_we), 32'd1);
    chk("tickpush_addr99", 32'(sid_addr), 32'h05);
    chk("tickpush_data99", 32'(sid_data), 32'h22);

    // Asynchronous reset in the middle of a queued burst.
    do_reset();
    step(1, 'h01, 'h11, 0, 0, 0, 0);
    step(1, 'h02, 'h22, 0, 0, 0, 0);
    step(1, 'h03, 'h33, 0, 0, 0, 0);
    idle_step();
    idle_step();
    chk("rst_level_before", 32'(fifo_level), 32'd3);
    @(posedge vga_clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_async_level", 32'(fifo_level), 32'd0);
    chk("rst_async_we", 32'(sid_we), 32'd0);
    chk("rst_async_ready", 32'({a_ready, b_ready}), 32'd3);
    do_reset();
    nwe = 0;
    for (int c = 0; c < 120; c++) begin
      idle_step();
      if (sid_we !== 1'b0) nwe++;
    end
    chk("rst_no_stale_write", nwe, 0);

    // Random requesters that hold their write until granted; bursts alternate with quiet spells.
    do_reset();
    a_pend = 1'b0;
    b_pend = 1'b0;
    pa = 0; pd = 0; pb = 0; pe = 0;
    for (int c = 0; c < 3000; c++) begin
      rate = ((c / 500) % 2 != 0) ? 30 : 3;
      if (!a_pend && $urandom_range(0, 99) < rate) begin
        a_pend = 1'b1;
        pa = int'($urandom_range(0, 31));
        pd = int'($urandom_range(0, 255));
      end
      if (!b_pend && $urandom_range(0, 99) < rate) begin
        b_pend = 1'b1;
        pb = int'($urandom_range(0, 31));
        pe = int'($urandom_range(0, 255));
      end
      step(int'(a_pend), pa, pd, int'(b_pend), pb, pe, ($urandom_range(0, 15) == 0) ? 1 : 0);
      if (last_ga) a_pend = 1'b0;
      if (last_gb) b_pend = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
